skew_feeder: RTL

SKEW_FEEDER -- requirements
Module: skew_feeder

---
 rtl/skew_feeder.sv | 102 ++++++++++
 1 files changed

// File: rtl/skew_feeder.sv
// Skewed operand feeder: reads one 4x4 operand block over seven steps so that
// line i starts i cycles after line 0, then registers the result for the array edge.
module skew_feeder #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      stall,
   output logic [3:0]                read_enable,
   output logic [7:0]                read_elem,
   input  logic [4*DATA_WIDTH-1:0]   mem_data,
   output logic [4*DATA_WIDTH-1:0]   feed_data,
   output logic                      feed_valid,
   output logic                      busy,
   output logic                      done
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam logic [2:0] LAST_STEP = 3'd6;

   state_t                    state_q, state_d;
   logic [2:0]                k_q, k_d;
   logic [4*DATA_WIDTH-1:0]   feed_data_q, feed_data_d;
   logic                      feed_valid_q, feed_valid_d;
   logic                      done_q, done_d;

   function automatic logic [4*DATA_WIDTH-1:0] mask_lanes(
      input logic [4*DATA_WIDTH-1:0] data,
      input logic [3:0]              en
   );
      logic [4*DATA_WIDTH-1:0] m;
      for (int i = 0; i < 4; i++) begin
         m[DATA_WIDTH*i +: DATA_WIDTH] = {DATA_WIDTH{en[i]}};
      end
      return data & m;
   endfunction

   // Line i is active for steps i..i+3 and reads element k-i during that window.
   always_comb begin
      read_enable = 4'b0000;
      read_elem   = 8'h00;
      for (int i = 0; i < 4; i++) begin
         if (state_q == RUN && int'(k_q) >= i && int'(k_q) <= i + 3) begin
            read_enable[i]     = 1'b1;
            read_elem[2*i +: 2] = 2'(int'(k_q) - i);
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      k_d          = k_q;
      feed_data_d  = feed_data_q;
      feed_valid_d = 1'b0;
      done_d       = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               k_d     = 3'd0;
            end
         end
         RUN: begin
            if (!stall) begin
               feed_data_d  = mask_lanes(mem_data, read_enable);
               feed_valid_d = 1'b1;
               if (k_q == LAST_STEP) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
                  k_d     = 3'd0;
               end else begin
                  k_d = k_q + 3'd1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         k_q          <= 3'd0;
         feed_data_q  <= '0;
         feed_valid_q <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         k_q          <= k_d;
         feed_data_q  <= feed_data_d;
         feed_valid_q <= feed_valid_d;
         done_q       <= done_d;
      end
   end

   assign feed_data  = feed_data_q;
   assign feed_valid = feed_valid_q;
   assign done       = done_q;
   assign busy       = (state_q == RUN);

endmodule
